data_sram_bridge: RTL

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

---
 rtl/data_sram_bridge_pkg.sv | 27 ++
 rtl/data_sram_bridge_wen_size_dec.sv | 32 +++
 rtl/data_sram_bridge.sv | 90 +++++++++
 3 files changed

// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg
//   Shared types and encodings for the CPU data-SRAM to SRAM-like bus bridge.
//   - state_t   : 2-bit FSM state encoding (IDLE/REQ/WAIT/DONE)
//   - SIZE_*    : bus data_size encodings
//   - mem_req_t : request fields latched when a CPU access is accepted
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Only the word address is kept; the byte offset on the bus is derived
  // from the write enables (reads are always word aligned).
  typedef struct packed {
    logic [29:0] word_addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_sram_bridge_wen_size_dec.sv
// wen_size_dec
//   Combinational map from CPU byte write enables to bus size and byte offset.
//   Ports:
//     wen    in  4  byte write enables (0 = read)
//     size   out 2  bus data_size
//     offset out 2  byte offset within the word
//   wen = 0 and irregular patterns fall back to a full word at offset 0, which
//   is also exactly what a read needs.
module wen_size_dec
  import data_sram_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic [1:0] size,
  output logic [1:0] offset
);

  always_comb begin
    size   = SIZE_WORD;
    offset = 2'd0;
    case (wen)
      4'b1111: begin size = SIZE_WORD; offset = 2'd0; end
      4'b0011: begin size = SIZE_HALF; offset = 2'd0; end
      4'b1100: begin size = SIZE_HALF; offset = 2'd2; end
      4'b0001: begin size = SIZE_BYTE; offset = 2'd0; end
      4'b0010: begin size = SIZE_BYTE; offset = 2'd1; end
      4'b0100: begin size = SIZE_BYTE; offset = 2'd2; end
      4'b1000: begin size = SIZE_BYTE; offset = 2'd3; end
      default: begin size = SIZE_WORD; offset = 2'd0; end
    endcase
  end

endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Converts the CPU's single-cycle data SRAM interface into an SRAM-like bus
//   transaction, stalling the pipeline until the response has been captured.
//   One transaction at a time: IDLE -> REQ (until addr_ok) -> WAIT (until
//   data_ok) -> DONE (until pipe_stall releases) -> IDLE.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     data_sram_en/wen/addr/wdata  CPU access request (EX stage)
//     pipe_stall               EX held by another stall source
//     data_sram_rdata          registered load data (MEM samples it)
//     stallreq                 stall request to the pipeline controller
//     data_req/wr/size/addr/wdata  bus request
//     data_addr_ok/data_ok/rdata   bus handshakes and read data
module data_sram_bridge
  import data_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        pipe_stall,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_t      state;
  mem_req_t    req_r;
  logic [31:0] rdata_r;
  logic [1:0]  dec_size;
  logic [1:0]  dec_off;

  // Low address bits are replaced by the wen-derived offset.
  logic addr_lo_unused;
  assign addr_lo_unused = ^data_sram_addr[1:0];

  wen_size_dec u_dec (
    .wen    (req_r.wen),
    .size   (dec_size),
    .offset (dec_off)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      req_r   <= '0;
      rdata_r <= '0;
    end else begin
      case (state)
        ST_IDLE: if (data_sram_en) begin
          req_r.word_addr <= data_sram_addr[31:2];
          req_r.wen       <= data_sram_wen;
          req_r.wdata     <= data_sram_wdata;
          state           <= ST_REQ;
        end
        // data_ok is deliberately not looked at here: the slave cannot
        // complete a transaction in the same cycle it accepts it.
        ST_REQ:  if (data_addr_ok) state <= ST_WAIT;
        ST_WAIT: if (data_data_ok) begin
          if (req_r.wen == 4'b0000) rdata_r <= data_rdata;
          state <= ST_DONE;
        end
        ST_DONE: if (!pipe_stall) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_req        = (state == ST_REQ);
  assign data_wr         = (req_r.wen != 4'b0000);
  assign data_size       = dec_size;
  assign data_addr       = {req_r.word_addr, dec_off};
  assign data_wdata      = req_r.wdata;
  assign data_sram_rdata = rdata_r;

  // Raised in IDLE the same cycle the access appears so EX holds immediately;
  // dropped in DONE so EX can advance while rdata_r is already valid.
  assign stallreq = !rst && ((state == ST_REQ) || (state == ST_WAIT) ||
                             ((state == ST_IDLE) && data_sram_en));

endmodule
